pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic multi-slot pipeline register with per-slot valid, ready/valid backpressure,
// flush and occupancy. Optional input skid entry enabled by PIPE_STAGE_SKID_EN.
module pipe_stage_reg #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned CTRL_W  = 9,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned STAGES  = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CTRL_W-1:0]               in_ctrl,
  input  logic [DATA_W-1:0]               in_data,
  input  logic [INSTR_W-1:0]              in_instr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CTRL_W-1:0]               out_ctrl,
  output logic [DATA_W-1:0]               out_data,
  output logic [INSTR_W-1:0]              out_instr,
  output logic [$clog2(STAGES+2)-1:0]     occupancy
);

  localparam int unsigned OccW = $clog2(STAGES + 2);

  logic [STAGES-1:0]  slotValid;
  logic [CTRL_W-1:0]  slotCtrl  [STAGES];
  logic [DATA_W-1:0]  slotData  [STAGES];
  logic [INSTR_W-1:0] slotInstr [STAGES];

  logic [STAGES:0]    ready;

  logic               srcValid;
  logic [CTRL_W-1:0]  srcCtrl;
  logic [DATA_W-1:0]  srcData;
  logic [INSTR_W-1:0] srcInstr;

  logic [STAGES-1:0]  prevValid;
  logic [CTRL_W-1:0]  prevCtrl  [STAGES];
  logic [DATA_W-1:0]  prevData  [STAGES];
  logic [INSTR_W-1:0] prevInstr [STAGES];

  // A slot may take a new beat when empty or when its successor is moving.
  always_comb begin
    ready = '0;
    ready[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      ready[i] = !slotValid[i] || ready[i+1];
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  logic               skidValid;
  logic [CTRL_W-1:0]  skidCtrl;
  logic [DATA_W-1:0]  skidData;
  logic [INSTR_W-1:0] skidInstr;

  // in_ready depends only on the skid flop (and flush), never on out_ready.
  assign in_ready = !skidValid && !flush;

  // A parked skid beat always has precedence over new input into slot 0.
  assign srcValid = skidValid || in_valid;
  assign srcCtrl  = skidValid ? skidCtrl  : in_ctrl;
  assign srcData  = skidValid ? skidData  : in_data;
  assign srcInstr = skidValid ? skidInstr : in_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skidValid <= 1'b0;
      skidCtrl  <= '0;
      skidData  <= '0;
      skidInstr <= '0;
    end else if (flush) begin
      skidValid <= 1'b0;
      skidCtrl  <= '0;
    end else if (skidValid) begin
      if (ready[0]) begin
        skidValid <= 1'b0;
        skidCtrl  <= '0;
      end
    end else if (in_valid && !ready[0]) begin
      skidValid <= 1'b1;
      skidCtrl  <= in_ctrl;
      skidData  <= in_data;
      skidInstr <= in_instr;
    end
  end
`else
  assign in_ready = ready[0] && !flush;
  assign srcValid = in_valid;
  assign srcCtrl  = in_ctrl;
  assign srcData  = in_data;
  assign srcInstr = in_instr;
`endif

  always_comb begin
    prevValid[0] = srcValid;
    prevCtrl[0]  = srcCtrl;
    prevData[0]  = srcData;
    prevInstr[0] = srcInstr;
    for (int i = 1; i < STAGES; i++) begin
      prevValid[i] = slotValid[i-1];
      prevCtrl[i]  = slotCtrl[i-1];
      prevData[i]  = slotData[i-1];
      prevInstr[i] = slotInstr[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotValid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        slotCtrl[i]  <= '0;
        slotData[i]  <= '0;
        slotInstr[i] <= '0;
      end
    end else if (flush) begin
      slotValid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        slotCtrl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (ready[i]) begin
          slotValid[i] <= prevValid[i];
          // Bubbles clear ctrl so no side effect leaks out; data/instr just hold.
          if (prevValid[i]) begin
            slotCtrl[i]  <= prevCtrl[i];
            slotData[i]  <= prevData[i];
            slotInstr[i] <= prevInstr[i];
          end else begin
            slotCtrl[i] <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OccW'(slotValid[i]);
    end
`ifdef PIPE_STAGE_SKID_EN
    occupancy = occupancy + OccW'(skidValid);
`endif
  end

  assign out_valid = slotValid[STAGES-1];
  assign out_ctrl  = slotValid[STAGES-1] ? slotCtrl[STAGES-1] : '0;
  assign out_data  = slotData[STAGES-1];
  assign out_instr = slotInstr[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg with STAGES=3.
module tb_pipe_stage_reg;

  localparam int unsigned Stages = 3;
`ifdef PIPE_STAGE_SKID_EN
  localparam int Cap = 4;
`else
  localparam int Cap = 3;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_ctrl;
  logic [63:0] in_data;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_ctrl;
  logic [63:0] out_data;
  logic [31:0] out_instr;
  logic [2:0]  occupancy;

  int nChecks;
  int nFails;

  pipe_stage_reg #(
    .DATA_W (64),
    .CTRL_W (9),
    .INSTR_W(32),
    .STAGES (Stages)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .in_instr (in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .out_instr(out_instr),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [8:0] c, input logic [31:0] ins);
    in_valid = v;
    in_ctrl  = c;
    in_instr = ins;
    in_data  = {ins, ~ins};
    #1;
  endtask

  initial begin
    int j;
    int acc;
    logic [31:0] ei;
    logic expV;

    nChecks   = 0;
    nFails    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 9'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkEq("rst_out_valid", 64'(out_valid), 64'd0);
    checkEq("rst_occ", 64'(occupancy), 64'd0);
    checkEq("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    rst_n = 1'b1;
    #1;
    checkEq("rst_in_ready", 64'(in_ready), 64'd1);

    // Passthrough: five back-to-back beats, three-cycle latency.
    for (int c = 0; c < 9; c++) begin
      if (c < 5) drive(1'b1, 9'(32'h11 + 32'(c)), 32'h11 + 32'(c));
      else       drive(1'b0, 9'h0, 32'h0);
      @(negedge clk);
      j    = c - 2;
      expV = (j >= 0) && (j < 5);
      ei   = 32'h11 + 32'(j);
      checkEq("pass_valid", 64'(out_valid), 64'(expV));
      if (expV) begin
        checkEq("pass_instr", 64'(out_instr), 64'(ei));
        checkEq("pass_ctrl", 64'(out_ctrl), 64'(ei[8:0]));
        checkEq("pass_data", out_data, {ei, ~ei});
      end
    end
    checkEq("pass_occ_end", 64'(occupancy), 64'd0);

    // Stall: out_ready low, keep offering beats.
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 9'(32'hA0 + 32'(acc)), 32'hA0 + 32'(acc));
      checkEq("stall_in_ready", 64'(in_ready), 64'(k < Cap));
      if (k < Cap) acc++;
      @(negedge clk);
    end
    checkEq("stall_occ", 64'(occupancy), 64'(Cap));
    checkEq("stall_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    drive(1'b0, 9'h0, 32'h0);
    for (int k = 0; k < Cap; k++) begin
      checkEq("drain_valid", 64'(out_valid), 64'd1);
      checkEq("drain_instr", 64'(out_instr), 64'(32'hA0 + 32'(k)));
      @(negedge clk);
    end
    checkEq("drain_empty", 64'(out_valid), 64'd0);
    checkEq("drain_occ", 64'(occupancy), 64'd0);

    // Flush with a beat in the last slot and one in slot 0, plus a competing input.
    drive(1'b1, 9'h031, 32'h31);
    @(negedge clk);
    drive(1'b0, 9'h0, 32'h0);
    @(negedge clk);
    drive(1'b1, 9'h032, 32'h32);
    @(negedge clk);
    checkEq("flush_pre_occ", 64'(occupancy), 64'd2);
    flush = 1'b1;
    drive(1'b1, 9'h077, 32'h77);
    checkEq("flush_in_ready", 64'(in_ready), 64'd0);
    checkEq("flush_out_valid", 64'(out_valid), 64'd1);
    checkEq("flush_out_instr", 64'(out_instr), 64'h31);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 9'h0, 32'h0);
    checkEq("flush_post_valid", 64'(out_valid), 64'd0);
    checkEq("flush_post_ctrl", 64'(out_ctrl), 64'd0);
    checkEq("flush_post_occ", 64'(occupancy), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkEq("flush_no_ghost", 64'(out_valid), 64'd0);
    end

    // Bubbles: alternate valid, ctrl all ones.
    for (int c = 0; c < 10; c++) begin
      if (c < 8) drive(1'(c % 2 == 0), 9'h1FF, 32'h50 + 32'(c));
      else       drive(1'b0, 9'h1FF, 32'h0);
      @(negedge clk);
      j    = c - 2;
      expV = (j >= 0) && (j < 8) && (j % 2 == 0);
      checkEq("bub_valid", 64'(out_valid), 64'(expV));
      checkEq("bub_ctrl", 64'(out_ctrl), expV ? 64'h1FF : 64'h0);
    end

`ifdef PIPE_STAGE_SKID_EN
    // Skid: fill pipe, drop out_ready as a new beat arrives.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 9'(32'hC0 + 32'(c)), 32'hC0 + 32'(c));
      @(negedge clk);
    end
    out_ready = 1'b0;
    drive(1'b1, 9'h0C3, 32'hC3);
    checkEq("skid_in_ready_pre", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(1'b0, 9'h0, 32'h0);
    checkEq("skid_in_ready_post", 64'(in_ready), 64'd0);
    checkEq("skid_occ", 64'(occupancy), 64'd4);
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checkEq("skid_valid", 64'(out_valid), 64'd1);
      checkEq("skid_instr", 64'(out_instr), 64'(32'hC0 + 32'(k)));
      @(negedge clk);
    end
    checkEq("skid_empty", 64'(out_valid), 64'd0);
`endif

    // Asynchronous reset mid-stream.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 9'(32'hE0 + 32'(c)), 32'hE0 + 32'(c));
      @(negedge clk);
    end
    checkEq("areset_pre_valid", 64'(out_valid), 64'd1);
    checkEq("areset_pre_instr", 64'(out_instr), 64'hE0);
    drive(1'b1, 9'h1FF, 32'hE3);
    #1;
    rst_n = 1'b0;
    #1;
    checkEq("areset_valid", 64'(out_valid), 64'd0);
    checkEq("areset_ctrl", 64'(out_ctrl), 64'd0);
    checkEq("areset_data", out_data, 64'd0);
    checkEq("areset_instr", 64'(out_instr), 64'd0);
    checkEq("areset_occ", 64'(occupancy), 64'd0);
    repeat (2) @(negedge clk);
    checkEq("areset_hold_valid", 64'(out_valid), 64'd0);
    checkEq("areset_hold_occ", 64'(occupancy), 64'd0);
    drive(1'b0, 9'h0, 32'h0);
    rst_n = 1'b1;
    #1;
    checkEq("areset_in_ready", 64'(in_ready), 64'd1);
    checkEq("areset_rel_occ", 64'(occupancy), 64'd0);
    @(negedge clk);
    checkEq("areset_idle_occ", 64'(occupancy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
